present_encryptor_top: RTL and testbench
========================================

Name: present_encryptor_top

Overview:
- Iterative PRESENT-80 block-cipher encryption core: 64-bit block, 80-bit key, one round per clock, 31 rounds plus final key whitening.
- Key and plaintext share a single 80-bit input bus and are loaded in separate cycles by two load strobes.
- Ciphertext is presented combinationally on data_o and held until the next load.
- Sits as a leaf crypto engine under a host controller that sequences the loads.

Parameters:
- none (fixed PRESENT-80 configuration)

Ports:
- clk_i  input  1  clock, all registers update on rising edge
- rst_i  input  1  asynchronous, active-high reset
- data_i  input  80  key (all 80 bits) when key_load=1; plaintext in data_i[63:0] when data_load=1, with data_i[79:64] ignored
- data_load  input  1  one-cycle strobe: load plaintext and start encryption
- key_load  input  1  one-cycle strobe: load 80-bit key
- data_o  output  64  state XOR key[79:16]; equals the ciphertext once encryption completes

Behaviour:
- Registers: state[63:0], key[79:0], round counter rc[4:0], busy flag.
- Reset (async, rst_i=1): state=0, key=0, rc=1, busy=0. Therefore data_o=0.
- data_o = state ^ key[79:16], purely combinational, at all times.
- key_load=1 at an edge:
  - key <= data_i.
  - rc <= 1, busy <= 0; any encryption in progress is aborted.
- data_load=1 at an edge:
  - state <= data_i[63:0], rc <= 1, busy <= 1.
  - The key register keeps the key loaded earlier.
- key_load and data_load both 1: both registers load, rc <= 1, busy <= 1. Hosts should not do this.
- data_load while busy: restarts encryption with the new plaintext and the current key register contents. The current key register may already be partially scheduled; hosts must reload the key first.
- Each edge with busy=1 and no load performs one round:
  - state <= P(S(state ^ key[79:16])).
  - key <= keyupdate(key, rc).
  - rc <= rc+1.
  - When rc==31 this round is the last: busy <= 0.
- Round function details:
  - S-box, applied to all 16 nibbles: input 0..F maps to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - P-layer: bit i moves to position (16*i) mod 63 for i=0..62; bit 63 stays at 63.
  - keyupdate, in order:
    1. Rotate key left by 61.
    2. key[79:76] <= S(key[79:76]).
    3. key[19:15] ^= rc.
- Latency:
  - data_o holds the ciphertext 31 rising edges after the data_load edge, that is, after rounds rc=1..31.
  - data_o then stays stable, with busy=0, until the next load or reset.
  - A new key_load may be issued on any cycle after completion. The standard cadence is key_load cycle, data_load cycle, then 31 run cycles.
- Idle (busy=0, no load): all registers hold.
- data_o is not meaningful as ciphertext while busy; it shows intermediate state XOR round key.
- Reset asserted mid-operation: immediate abort to reset values.

Test Plan:
- Reset: assert rst_i for 2 cycles -> data_o=0000000000000000. Release rst_i with no loads -> data_o stays 0.
- key=00000000000000000000 (key_load 1 cycle), then plaintext 0000000000000000 (data_load 1 cycle), wait 31 cycles -> data_o=5579C1387B228445, held for 3 more cycles.
- key=FFFFFFFFFFFFFFFFFFFF, plaintext 0 -> data_o=E72C46C0F5945049 after 31 cycles.
- key=0, plaintext FFFFFFFFFFFFFFFF -> A112FFC72F68417B. Key all-F, plaintext all-F -> 3333DCD3213210D2.
- Back-to-back: run the four vectors above consecutively with no idle gap (key_load, data_load, 31 cycles, repeat) -> each vector's ciphertext appears; no state carries over between vectors.
- Abort: start key=0/plaintext=0; at round 10 issue key_load=FF..F then data_load=FF..F -> after 31 further cycles data_o=3333DCD3213210D2. Separately, assert rst_i mid-run -> data_o=0 immediately, asynchronously.

Source files
------------

// File: rtl/present_encryptor_top.sv
// rtl/present_encryptor_top.sv - iterative PRESENT-80 encryption core, one round per clock
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset
//   data_i     80-bit key on key_load, plaintext in [63:0] on data_load
//   data_load  strobe: latch plaintext and start encryption
//   key_load   strobe: latch key, abort any encryption in progress
//   data_o     state ^ key[79:16]; the ciphertext once the 31 rounds are done

module present_encryptor_top (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [79:0] data_i,
  input  logic        data_load,
  input  logic        key_load,
  output logic [63:0] data_o
);

  logic [63:0] state;
  logic [79:0] key;
  logic [4:0]  rc;
  logic        busy;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[n*4 +: 4] = sbox(s[n*4 +: 4]);
    end
    return r;
  endfunction

  // Bit i lands at (16*i) mod 63; bit 63 is a fixed point of the permutation.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[(i * 16) % 63] = s[i];
    end
    r[63] = s[63];
    return r;
  endfunction

  // Round-key schedule: rotate left 61, S-box the top nibble, mix in the round counter.
  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ c;
    return r;
  endfunction

  logic [63:0] round_state;
  logic [79:0] round_key;

  always_comb begin
    round_state = p_layer(sbox_layer(state ^ key[79:16]));
    round_key   = key_update(key, rc);
  end

  assign data_o = state ^ key[79:16];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= '0;
      key   <= '0;
      rc    <= 5'd1;
      busy  <= 1'b0;
    end else if (key_load || data_load) begin
      // Loads take priority over a round; a key load alone leaves the core idle.
      if (key_load) begin
        key <= data_i;
      end
      if (data_load) begin
        state <= data_i[63:0];
      end
      rc   <= 5'd1;
      busy <= data_load;
    end else if (busy) begin
      state <= round_state;
      key   <= round_key;
      rc    <= rc + 5'd1;
      if (rc == 5'd31) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_present_encryptor_top.sv
// tb/tb_present_encryptor_top.sv - directed and randomized checks of present_encryptor_top

module tb_present_encryptor_top;

  logic        clk_i;
  logic        rst_i;
  logic [79:0] data_i;
  logic        data_load;
  logic        key_load;
  logic [63:0] data_o;

  int tests_run;
  int tests_failed;

  present_encryptor_top dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .data_load (data_load),
    .key_load  (key_load),
    .data_o    (data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference model: whole-block cipher arithmetic with a lookup table and shift-based rotation.
  function automatic logic [3:0] ref_sb(input logic [3:0] x);
    logic [63:0] table_c;
    table_c = 64'h21748FE3DA09B65C;   // nibble x of this word is S(x)
    return table_c[x*4 +: 4];
  endfunction

  function automatic logic [79:0] ref_key_after(input logic [79:0] k0, input int n);
    logic [79:0] k;
    k = k0;
    for (int r = 1; r <= n; r++) begin
      k = (k << 61) | (k >> 19);
      k[79:76] = ref_sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return k;
  endfunction

  function automatic logic [63:0] ref_state_after(input logic [79:0] k0, input logic [63:0] p, input int n);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    int          dst;
    s = p;
    k = k0;
    for (int r = 1; r <= n; r++) begin
      s = s ^ k[79:16];
      for (int m = 0; m < 16; m++) s[m*4 +: 4] = ref_sb(s[m*4 +: 4]);
      t = '0;
      for (int b = 0; b < 64; b++) begin
        dst = (b == 63) ? 63 : (b * 16) % 63;
        t[dst] = s[b];
      end
      s = t;
      k = ref_key_after(k0, r);
    end
    return s;
  endfunction

  function automatic logic [63:0] ref_out(input logic [79:0] k0, input logic [63:0] p, input int n);
    logic [79:0] kn;
    kn = ref_key_after(k0, n);
    return ref_state_after(k0, p, n) ^ kn[79:16];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic load_key(input logic [79:0] k);
    data_i   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    data_i   = {$urandom, $urandom, $urandom};
  endtask

  task automatic load_data(input logic [63:0] p);
    data_i    = {16'($urandom), p};
    data_load = 1'b1;
    tick();
    data_load = 1'b0;
    data_i    = {$urandom, $urandom, $urandom};
  endtask

  logic [79:0] kv [4];
  logic [63:0] pv [4];
  logic [63:0] cv [4];
  logic [79:0] rk;
  logic [63:0] rp;
  logic [79:0] k2;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    data_i       = '0;
    data_load    = 1'b0;
    key_load     = 1'b0;

    kv[0] = '0;         pv[0] = '0;         cv[0] = 64'h5579C1387B228445;
    kv[1] = {80{1'b1}}; pv[1] = '0;         cv[1] = 64'hE72C46C0F5945049;
    kv[2] = '0;         pv[2] = {64{1'b1}}; cv[2] = 64'hA112FFC72F68417B;
    kv[3] = {80{1'b1}}; pv[3] = {64{1'b1}}; cv[3] = 64'h3333DCD3213210D2;

    // Reset
    repeat (2) tick();
    check("reset_out", data_o, 64'h0);
    rst_i = 1'b0;
    repeat (2) tick();
    check("idle_after_reset", data_o, 64'h0);

    // First vector with hold afterwards
    load_key(kv[0]);
    load_data(pv[0]);
    repeat (31) tick();
    check("vec0_ct", data_o, cv[0]);
    for (int h = 1; h <= 3; h++) begin
      tick();
      check($sformatf("vec0_hold%0d", h), data_o, cv[0]);
    end

    // Back-to-back known vectors
    for (int v = 0; v < 4; v++) begin
      load_key(kv[v]);
      load_data(pv[v]);
      repeat (31) tick();
      check($sformatf("b2b_vec%0d", v), data_o, cv[v]);
    end

    // Random vectors, every intermediate round checked against the model
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom};
      rp = {$urandom, $urandom};
      load_key(rk);
      load_data(rp);
      check($sformatf("rand%0d_r0", n), data_o, ref_out(rk, rp, 0));
      for (int r = 1; r <= 31; r++) begin
        tick();
        check($sformatf("rand%0d_r%0d", n, r), data_o, ref_out(rk, rp, r));
      end
      repeat (2) tick();
      check($sformatf("rand%0d_hold", n), data_o, ref_out(rk, rp, 31));
    end

    // Abort at round 10 with a fresh key and plaintext
    load_key(kv[0]);
    load_data(pv[0]);
    repeat (9) tick();
    load_key(kv[3]);
    load_data(pv[3]);
    repeat (31) tick();
    check("abort_restart_ct", data_o, cv[3]);

    // Key load alone mid-run stops the rounds; state holds under the new key
    rk = {$urandom, $urandom, $urandom};
    rp = {$urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom};
    load_key(rk);
    load_data(rp);
    repeat (5) tick();
    load_key(k2);
    check("keyload_abort", data_o, ref_state_after(rk, rp, 5) ^ k2[79:16]);
    repeat (4) tick();
    check("keyload_abort_hold", data_o, ref_state_after(rk, rp, 5) ^ k2[79:16]);

    // Asynchronous reset mid-run
    load_key(kv[1]);
    load_data(pv[2]);
    repeat (4) tick();
    check("pre_async_reset", data_o, ref_out(kv[1], pv[2], 4));
    #3;
    rst_i = 1'b1;
    #1;
    check("async_reset_immediate", data_o, 64'h0);
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    check("after_async_reset", data_o, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
